// File: rtl/tcu_priv_timer_multi.sv
// Multi-channel nanosecond countdown timers (one-shot or periodic) whose expiries
// are merged round-robin onto a single registered valid/stall interrupt slot.
module tcu_priv_timer_multi #(
    parameter int NUM_TIMERS  = 4,
    parameter int IDX_SIZE    = 2,
    parameter int TIMER_SIZE  = 32,
    parameter int CLKFREQ_MHZ = 100
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  timer_wr_valid_i,
    input  logic [IDX_SIZE-1:0]   timer_wr_idx_i,
    input  logic [TIMER_SIZE-1:0] timer_wr_value_i,
    input  logic                  timer_wr_periodic_i,
    input  logic                  timer_int_stall_i,
    output logic                  timer_int_valid_o,
    output logic [IDX_SIZE-1:0]   timer_int_idx_o,
    output logic [NUM_TIMERS-1:0] timer_active_o
);

    localparam logic [TIMER_SIZE-1:0] TIMER_FACTOR = TIMER_SIZE'(1000 / CLKFREQ_MHZ);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    ch_state_e             state_q  [NUM_TIMERS];
    logic [TIMER_SIZE-1:0] count_q  [NUM_TIMERS];
    logic [TIMER_SIZE-1:0] period_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] periodic_q;
    logic [NUM_TIMERS-1:0] pending_q;

    logic [NUM_TIMERS-1:0] wr_hit;
    logic [NUM_TIMERS-1:0] expire;
    logic [NUM_TIMERS-1:0] grant_clr;

    logic                  int_valid_q;
    logic [IDX_SIZE-1:0]   int_idx_q;
    logic [IDX_SIZE-1:0]   rr_q;

    logic                  slot_load;
    logic                  grant_found;
    logic [IDX_SIZE-1:0]   grant_idx;
    logic [IDX_SIZE-1:0]   grant_next_rr;
    logic [IDX_SIZE-1:0]   cand;

    // Valid/stall handshake: the slot is accepted in any cycle where valid && !stall;
    // while stalled it holds valid and idx unchanged and nothing else may load it.
    assign slot_load = !int_valid_q || !timer_int_stall_i;

    always_comb begin
        wr_hit    = '0;
        expire    = '0;
        grant_clr = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            wr_hit[i] = timer_wr_valid_i && (timer_wr_idx_i == IDX_SIZE'(i));
            // Compare before subtract so the countdown can never wrap.
            expire[i] = (state_q[i] == CH_RUN) && !wr_hit[i] && (count_q[i] <= TIMER_FACTOR);
            grant_clr[i] = slot_load && grant_found && (grant_idx == IDX_SIZE'(i));
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            cand = IDX_SIZE'((int'(rr_q) + k) % NUM_TIMERS);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_next_rr = IDX_SIZE'((int'(grant_idx) + 1) % NUM_TIMERS);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                state_q[i]  <= CH_IDLE;
                count_q[i]  <= '0;
                period_q[i] <= '0;
            end
            periodic_q <= '0;
            pending_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr_hit[i]) begin
                    pending_q[i] <= 1'b0;
                    if (timer_wr_value_i != '0) begin
                        state_q[i]    <= CH_RUN;
                        count_q[i]    <= timer_wr_value_i;
                        period_q[i]   <= timer_wr_value_i;
                        periodic_q[i] <= timer_wr_periodic_i;
                    end else begin
                        state_q[i] <= CH_IDLE;
                    end
                end else if (expire[i]) begin
                    // A new expiry beats a same-cycle grant, so another interrupt follows.
                    pending_q[i] <= 1'b1;
                    if (periodic_q[i]) begin
                        count_q[i] <= period_q[i];
                    end else begin
                        state_q[i] <= CH_IDLE;
                    end
                end else begin
                    if (grant_clr[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                    if (state_q[i] == CH_RUN) begin
                        count_q[i] <= count_q[i] - TIMER_FACTOR;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int_valid_q <= 1'b0;
            int_idx_q   <= '0;
            rr_q        <= '0;
        end else if (slot_load) begin
            int_valid_q <= grant_found;
            if (grant_found) begin
                int_idx_q <= grant_idx;
                rr_q      <= grant_next_rr;
            end
        end
    end

    always_comb begin
        timer_active_o = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            timer_active_o[i] = (state_q[i] == CH_RUN);
        end
    end

    assign timer_int_valid_o = int_valid_q;
    assign timer_int_idx_o   = int_idx_q;

endmodule

// File: tb/tb_tcu_priv_timer_multi.sv
// Bench for tcu_priv_timer_multi: an expiry-time model (absolute cycle of next expiry
// per channel) checked every cycle, plus directed scenarios with literal expectations.
module tb_tcu_priv_timer_multi;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TW = 32;
    localparam int F  = 10;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          wr_valid = 1'b0;
    logic [IW-1:0] wr_idx   = '0;
    logic [TW-1:0] wr_value = '0;
    logic          wr_per   = 1'b0;
    logic          stall    = 1'b0;
    logic          int_valid;
    logic [IW-1:0] int_idx;
    logic [N-1:0]  active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcu_priv_timer_multi #(
        .NUM_TIMERS (N),
        .IDX_SIZE   (IW),
        .TIMER_SIZE (TW),
        .CLKFREQ_MHZ(100)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .timer_wr_valid_i   (wr_valid),
        .timer_wr_idx_i     (wr_idx),
        .timer_wr_value_i   (wr_value),
        .timer_wr_periodic_i(wr_per),
        .timer_int_stall_i  (stall),
        .timer_int_valid_o  (int_valid),
        .timer_int_idx_o    (int_idx),
        .timer_active_o     (active)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel expires at an absolute edge number,
    // ceil(value/F) edges after the write edge (at least one), then every period.
    longint      now = 0;
    logic [N-1:0] m_run, m_pend, m_per;
    longint      m_next [N];
    longint      m_k    [N];
    logic        m_valid;
    int          m_idx, m_rr, pick, c;
    bit          free, hit;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = '0; m_pend = '0; m_per = '0;
            m_valid = 1'b0; m_idx = 0; m_rr = 0;
            for (int i = 0; i < N; i++) begin
                m_next[i] = 0;
                m_k[i]    = 1;
            end
        end else begin
            pick = -1;
            free = !m_valid || !stall;
            if (free) begin
                for (int j = 0; j < N; j++) begin
                    c = (m_rr + j) % N;
                    if (pick < 0 && m_pend[c]) pick = c;
                end
            end
            for (int i = 0; i < N; i++) begin
                hit = wr_valid && (int'(wr_idx) == i);
                if (hit) begin
                    m_pend[i] = 1'b0;
                    if (wr_value != 0) begin
                        m_run[i]  = 1'b1;
                        m_per[i]  = wr_per;
                        m_k[i]    = (longint'(wr_value) + F - 1) / F;
                        m_next[i] = now + m_k[i];
                    end else begin
                        m_run[i] = 1'b0;
                    end
                end else if (m_run[i] && now == m_next[i]) begin
                    m_pend[i] = 1'b1;
                    if (m_per[i]) m_next[i] = now + m_k[i];
                    else m_run[i] = 1'b0;
                end else if (pick == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (free) begin
                m_valid = (pick >= 0);
                if (pick >= 0) begin
                    m_idx = pick;
                    m_rr  = (pick + 1) % N;
                end
            end
            now++;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_valid", int_valid, m_valid);
            if (m_valid) chk("model_idx", int_idx, m_idx);
            chk("model_active", active, m_run);
        end
    end

    task automatic wr(input int idx, input longint val, input bit per);
        logic [63:0] v;
        logic [31:0] ix;
        v = val; ix = idx;
        wr_valid = 1'b1; wr_idx = ix[IW-1:0]; wr_value = v[TW-1:0]; wr_per = per;
        @(negedge clk);
        wr_valid = 1'b0; wr_value = '0; wr_per = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!int_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk(name, (t < 30), 1);
    endtask

    int cnt;
    int sel;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("reset_valid", int_valid, 0);
        chk("reset_idx", int_idx, 0);
        chk("reset_active", active, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // One-shot 50 ns: expiry at write+5, inactive from +5, valid at +6 only.
        wr(0, 50, 0);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 4) chk("t1_active_before", active[0], 1);
            if (n == 5) begin
                chk("t1_active_after", active[0], 0);
                chk("t1_valid_early", int_valid, 0);
            end
            if (n == 6) begin
                chk("t1_valid", int_valid, 1);
                chk("t1_idx", int_idx, 0);
            end
            if (n == 7) chk("t1_valid_drop", int_valid, 0);
        end

        // Periodic 30 ns on ch1: one interrupt every 3 cycles, then stop.
        wr(1, 30, 1);
        cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (int_valid && int_idx == 1) cnt++;
        end
        chk("t2_periodic_count", cnt, 3);
        wr(1, 0, 0);
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (int_valid) cnt++;
        end
        chk("t2_after_stop", cnt, 0);
        chk("t2_active1", active[1], 0);

        // All four channels expire on the same edge while stalled.
        do_reset();
        stall = 1'b1;
        wr(0, 40, 0); wr(1, 30, 0); wr(2, 20, 0); wr(3, 10, 0);
        repeat (2) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            chk("t3_hold_valid", int_valid, 1);
            chk("t3_hold_idx", int_idx, 0);
            if (n < 4) @(negedge clk);
        end
        stall = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("t3_seq_valid", int_valid, 1);
            chk("t3_seq_idx", int_idx, n);
        end
        @(negedge clk);
        chk("t3_drain", int_valid, 0);

        // Round-robin between two channels expiring every cycle.
        do_reset();
        wr(0, 10, 1);
        wr(2, 10, 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t4_rr_valid", int_valid, 1);
            chk("t4_rr_idx", int_idx, (n % 2 == 0) ? 0 : 2);
        end
        wr(0, 0, 0);
        wr(2, 0, 0);
        repeat (4) @(negedge clk);

        // Rewrite a channel whose interrupt is already presented under stall.
        do_reset();
        stall = 1'b1;
        wr(2, 10, 0);
        wait_valid("t5_wait");
        wr(2, 100, 0);
        for (int n = 0; n < 3; n++) begin
            chk("t5_held_valid", int_valid, 1);
            chk("t5_held_idx", int_idx, 2);
            @(negedge clk);
        end
        stall = 1'b0;
        cnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (int_valid) cnt++;
        end
        chk("t5_single_new", cnt, 1);

        // Asynchronous reset mid-count and during valid && stall.
        do_reset();
        stall = 1'b1;
        wr(0, 10, 0);
        wr(1, 200, 1);
        wait_valid("t6_wait");
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", int_valid, 0);
        chk("t6_async_idx", int_idx, 0);
        chk("t6_async_active", active, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (int_valid || active != 0) cnt++;
        end
        chk("t6_quiet", cnt, 0);

        // Random writes and stalls, checked by the model every cycle.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 9);
                wr_valid = 1'b1;
                wr_idx   = IW'($urandom_range(0, N - 1));
                wr_per   = $urandom_range(0, 1);
                if (sel == 0) wr_value = '0;
                else if (sel <= 2) wr_value = TW'($urandom_range(1, 9));
                else wr_value = TW'($urandom_range(10, 80));
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        stall = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
